axis_video_frame_checker: RTL and testbench



---
 rtl/axis_video_frame_checker_pkg.sv | 19 +
 rtl/axis_video_frame_checker_if.sv | 29 ++
 rtl/axis_pixel_position_counter.sv | 50 +++++
 rtl/axis_video_frame_checker.sv | 166 ++++++++++++++++
 tb/tb_axis_video_frame_checker.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_video_frame_checker_pkg.sv
// Shared definitions for the AXI4-Stream video frame checker: FSM states,
// error flag bit positions and result widths.
package axis_video_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } frame_state_e;

    localparam int ERR_SOF_MISSING = 0;
    localparam int ERR_SOF_EARLY   = 1;
    localparam int ERR_EOL_MISSING = 2;
    localparam int ERR_EOL_EARLY   = 3;
    localparam int ERR_W           = 4;

    localparam int CHECKSUM_W  = 32;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/axis_video_frame_checker_if.sv
// AXI4-Stream video bus: pixel data plus start-of-frame (tuser) and
// end-of-line (tlast) markers.
interface axis_video_frame_checker_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tuser;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_pixel_position_counter.sv
// Tracks the (x, y) position of the next expected pixel within a frame.
// load restarts at (1, 0) because the loading beat itself is pixel (0, 0).
module axis_pixel_position_counter #(
    parameter int IMG_WIDTH  = 12,
    parameter int IMG_HEIGHT = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          step,
    input  logic                          wrap,
    output logic [$clog2(IMG_WIDTH)-1:0]  x,
    output logic [$clog2(IMG_HEIGHT)-1:0] y,
    output logic                          last_in_line,
    output logic                          last_line
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;

    // Position update; wrapping off the last line returns y to 0 so the
    // counter never leaves its legal range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= {XW{1'b0}};
            y_r <= {YW{1'b0}};
        end else if (load) begin
            x_r <= XW'(1);
            y_r <= {YW{1'b0}};
        end else if (wrap) begin
            x_r <= {XW{1'b0}};
            y_r <= last_line ? {YW{1'b0}} : (y_r + YW'(1));
        end else if (step) begin
            x_r <= x_r + XW'(1);
            y_r <= y_r;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign x            = x_r;
    assign y            = y_r;
    assign last_in_line = (x_r == XW'(IMG_WIDTH - 1));
    assign last_line    = (y_r == YW'(IMG_HEIGHT - 1));

endmodule

// File: rtl/axis_video_frame_checker.sv
// AXI4-Stream video sink: checks tuser/tlast framing against the configured
// geometry, and reports per-frame checksum, frame count and sticky errors.
module axis_video_frame_checker
    import axis_video_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 12,
    parameter int IMG_HEIGHT = 12
) (
    input  logic                      i_clk,
    input  logic                      i_areset,
    axis_video_frame_checker_if.slave s_axis,
    input  logic                      i_stall,
    input  logic                      i_clear_err,
    output logic                      o_frame_done,
    output logic [FRAME_CNT_W-1:0]    o_frame_cnt,
    output logic [CHECKSUM_W-1:0]     o_checksum,
    output logic [ERR_W-1:0]          o_err,
    output logic                      o_busy
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    frame_state_e           state_r;
    frame_state_e           state_nxt_s;
    logic [CHECKSUM_W-1:0]  acc_r;
    logic [CHECKSUM_W-1:0]  acc_nxt_s;
    logic [CHECKSUM_W-1:0]  checksum_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [ERR_W-1:0]       err_r;
    logic [ERR_W-1:0]       err_set_s;
    logic                   frame_done_r;
    logic                   busy_r;
    logic                   done_s;

    logic                   tready_s;
    logic                   accepted_s;
    logic [DATA_WIDTH-1:0]  pix_s;
    logic [CHECKSUM_W-1:0]  pix_ext_s;

    logic                   load_s;
    logic                   step_s;
    logic                   wrap_s;
    logic [XW-1:0]          pos_x_s;
    logic [YW-1:0]          pos_y_s;
    logic                   last_in_line_s;
    logic                   last_line_s;
    logic                   unused_pos_y_s;

    assign tready_s      = !i_stall && !i_areset;
    assign s_axis.tready = tready_s;
    assign accepted_s    = s_axis.tvalid && tready_s;
    assign pix_s         = s_axis.tdata;
    assign pix_ext_s     = CHECKSUM_W'(pix_s);

    // Line completion is decided from the last_line flag; y itself is not needed here.
    assign unused_pos_y_s = ^pos_y_s;

    axis_pixel_position_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk          (i_clk),
        .rst          (i_areset),
        .load         (load_s),
        .step         (step_s),
        .wrap         (wrap_s),
        .x            (pos_x_s),
        .y            (pos_y_s),
        .last_in_line (last_in_line_s),
        .last_line    (last_line_s)
    );

    // Per-beat framing decisions: next state, counter controls, new errors.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        wrap_s      = 1'b0;
        done_s      = 1'b0;
        err_set_s   = {ERR_W{1'b0}};
        if (accepted_s) begin
            case (state_r)
                IDLE: begin
                    if (s_axis.tuser) begin
                        load_s      = 1'b1;
                        acc_nxt_s   = pix_ext_s;
                        state_nxt_s = RECV;
                    end else begin
                        err_set_s[ERR_SOF_MISSING] = 1'b1;
                    end
                end
                RECV: begin
                    if (s_axis.tuser) begin
                        // A new start-of-frame mid-frame restarts at pixel (0,0).
                        err_set_s[ERR_SOF_EARLY] = 1'b1;
                        load_s                   = 1'b1;
                        acc_nxt_s                = pix_ext_s;
                    end else if (last_in_line_s || s_axis.tlast) begin
                        acc_nxt_s                  = acc_r + pix_ext_s;
                        wrap_s                     = 1'b1;
                        err_set_s[ERR_EOL_MISSING] = !s_axis.tlast;
                        err_set_s[ERR_EOL_EARLY]   = s_axis.tlast && (pos_x_s < XW'(IMG_WIDTH - 1));
                        if (last_line_s) begin
                            done_s      = 1'b1;
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = RECV;
                        end
                    end else begin
                        acc_nxt_s = acc_r + pix_ext_s;
                        step_s    = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and running frame sum.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_r <= IDLE;
            acc_r   <= {CHECKSUM_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
        end
    end

    // Frame results, sticky error flags and busy indication.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            frame_done_r <= 1'b0;
            checksum_r   <= {CHECKSUM_W{1'b0}};
            frame_cnt_r  <= {FRAME_CNT_W{1'b0}};
            err_r        <= {ERR_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            if (done_s) begin
                checksum_r  <= acc_nxt_s;
                frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            end else begin
                checksum_r  <= checksum_r;
                frame_cnt_r <= frame_cnt_r;
            end
            // A new error in the clearing cycle wins over the clear.
            err_r  <= (i_clear_err ? {ERR_W{1'b0}} : err_r) | err_set_s;
            busy_r <= (state_r == RECV);
        end
    end

    assign o_frame_done = frame_done_r;
    assign o_checksum   = checksum_r;
    assign o_frame_cnt  = frame_cnt_r;
    assign o_err        = err_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// Randomized bench for axis_video_frame_checker with a beat-level reference
// model; every clock edge is compared against the model.
module tb_axis_video_frame_checker;

    localparam int DW = 8;
    localparam int W  = 12;
    localparam int H  = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        clear_err;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [31:0] checksum;
    logic [3:0]  err;
    logic        busy;

    axis_video_frame_checker_if #(.DATA_WIDTH(DW)) axis_if ();

    always #5 clk = ~clk;

    axis_video_frame_checker #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk        (clk),
        .i_areset     (rst),
        .s_axis       (axis_if),
        .i_stall      (stall),
        .i_clear_err  (clear_err),
        .o_frame_done (frame_done),
        .o_frame_cnt  (frame_cnt),
        .o_checksum   (checksum),
        .o_err        (err),
        .o_busy       (busy)
    );

    typedef struct {
        bit         user;
        bit         last;
        logic [7:0] data;
    } beat_t;

    beat_t beats_q[$];

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Reference model: frame receiver described as "pixel col of line row".
    bit          m_in_frame;
    int          m_col;
    int          m_row;
    logic [31:0] m_acc;
    logic [31:0] m_sum;
    logic [15:0] m_cnt;
    logic [3:0]  m_err;
    bit          m_done;
    bit          m_busy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_col = 0;
        m_row = 0;
        m_acc = 32'd0;
        m_sum = 32'd0;
        m_cnt = 16'd0;
        m_err = 4'd0;
        m_done = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge(input bit v, input bit u, input bit l, input logic [7:0] d,
                              input bit st, input bit clr);
        logic [3:0] new_err;
        new_err = 4'd0;
        m_busy = m_in_frame;
        m_done = 1'b0;
        if (v && !st) begin
            if (u) begin
                if (m_in_frame) new_err[1] = 1'b1;
                m_in_frame = 1'b1;
                m_col = 1;
                m_row = 0;
                m_acc = 32'(d);
            end else if (!m_in_frame) begin
                new_err[0] = 1'b1;
            end else begin
                m_acc = m_acc + 32'(d);
                if (m_col == W - 1 || l) begin
                    if (!l) new_err[2] = 1'b1;
                    if (l && m_col != W - 1) new_err[3] = 1'b1;
                    if (m_row == H - 1) begin
                        m_in_frame = 1'b0;
                        m_done = 1'b1;
                        m_sum = m_acc;
                        m_cnt = m_cnt + 16'd1;
                    end
                    m_col = 0;
                    m_row = m_row + 1;
                end else begin
                    m_col = m_col + 1;
                end
            end
        end
        m_err = (clr ? 4'd0 : m_err) | new_err;
    endtask

    task automatic check_outputs();
        check_val("frame_done", {31'd0, frame_done}, {31'd0, m_done});
        check_val("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        check_val("checksum", checksum, m_sum);
        check_val("err", {28'd0, err}, {28'd0, m_err});
        check_val("busy", {31'd0, busy}, {31'd0, m_busy});
    endtask

    // One clock: drive after the falling edge, model and compare after the rising edge.
    task automatic cycle(input bit v, input bit u, input bit l, input logic [7:0] d,
                         input bit st, input bit clr);
        @(negedge clk);
        axis_if.tvalid = v;
        axis_if.tuser  = u;
        axis_if.tlast  = l;
        axis_if.tdata  = d;
        stall          = st;
        clear_err      = clr;
        #1;
        check_val("tready", {31'd0, axis_if.tready}, {31'd0, !st});
        @(posedge clk);
        model_edge(v, u, l, d, st, clr);
        #1;
        check_outputs();
        if (frame_done) done_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Queue one frame; a short line ends with tlast after short_len pixels,
    // and only the first n_beats beats are queued.
    task automatic append_frame(input bit seq, input int miss_line, input int short_line,
                                input int short_len, input int n_beats);
        int k;
        int len;
        beat_t b;
        k = 0;
        for (int y = 0; y < H; y++) begin
            len = (y == short_line) ? short_len : W;
            for (int x = 0; x < len; x++) begin
                b.user = (k == 0);
                b.last = (x == len - 1) && !(y == miss_line);
                b.data = seq ? 8'(k + 1) : 8'($urandom_range(255));
                if (k < n_beats) beats_q.push_back(b);
                k++;
            end
        end
    endtask

    task automatic append_stray(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.user = 1'b0;
            b.last = ($urandom_range(1) == 1);
            b.data = 8'($urandom_range(255));
            beats_q.push_back(b);
        end
    endtask

    // Send all queued beats; stall_mode 0 none, 1 toggle, 2 random.
    task automatic run_beats(input int stall_mode, input int gap_pct);
        int    cyc;
        bit    tog;
        bit    v;
        bit    st;
        beat_t b;
        cyc = 0;
        tog = 1'b0;
        while (beats_q.size() > 0 && cyc < 20000) begin
            v  = ($urandom_range(99) >= gap_pct);
            st = (stall_mode == 1) ? tog : (stall_mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
            tog = !tog;
            b = beats_q[0];
            cycle(v, b.user, b.last, b.data, st, 1'b0);
            if (v && !st) void'(beats_q.pop_front());
            cyc++;
        end
        if (beats_q.size() != 0) begin
            check_val("beat_budget", beats_q.size(), 0);
            beats_q.delete();
        end
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        axis_if.tvalid = 1'b1;
        axis_if.tuser  = 1'b1;
        stall = 1'b0;
        clear_err = 1'b0;
        #1;
        model_reset();
        check_val("tready_in_reset", {31'd0, axis_if.tready}, 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        axis_if.tvalid = 1'b0;
        axis_if.tuser  = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check_outputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1;
        stall = 1'b0;
        clear_err = 1'b0;
        axis_if.tvalid = 1'b0;
        axis_if.tuser  = 1'b0;
        axis_if.tlast  = 1'b0;
        axis_if.tdata  = 8'h00;
        model_reset();

        // Reset state
        do_reset();

        // Clean frame of pixels 1..144, continuous valid
        d0 = done_seen;
        append_frame(1'b1, -1, -1, W, W * H);
        run_beats(0, 0);
        check_val("t1_checksum", checksum, 32'd10440);
        check_val("t1_cnt", {16'd0, frame_cnt}, 32'd1);
        check_val("t1_err", {28'd0, err}, 32'd0);
        check_val("t1_done_pulses", done_seen - d0, 1);

        // Same frame with stall toggling every other cycle
        append_frame(1'b1, -1, -1, W, W * H);
        run_beats(1, 0);
        check_val("t2_checksum", checksum, 32'd10440);
        check_val("t2_cnt", {16'd0, frame_cnt}, 32'd2);

        // Five beats without tuser, then a clean frame
        append_stray(5);
        append_frame(1'b1, -1, -1, W, W * H);
        run_beats(0, 10);
        check_val("t3_err", {28'd0, err}, 32'h1);
        check_val("t3_checksum", checksum, 32'd10440);

        // Missing tlast on line 3, short line 7 (tlast at x=5)
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        append_frame(1'b1, 3, 7, 6, W * H);
        run_beats(0, 0);
        check_val("t4_err", {28'd0, err}, 32'hC);
        check_val("t4_checksum", checksum, 32'd9591);

        // tuser re-asserted at pixel 50, then a full clean frame
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        d0 = done_seen;
        append_frame(1'b1, -1, -1, W, 49);
        append_frame(1'b1, -1, -1, W, W * H);
        run_beats(2, 15);
        check_val("t5_err", {28'd0, err}, 32'h2);
        check_val("t5_done_pulses", done_seen - d0, 1);
        check_val("t5_checksum", checksum, 32'd10440);

        // Reset in mid-frame, then a clean frame
        append_frame(1'b0, -1, -1, W, 60);
        run_beats(0, 0);
        do_reset();
        append_frame(1'b1, -1, -1, W, W * H);
        run_beats(0, 0);
        check_val("t6_cnt", {16'd0, frame_cnt}, 32'd1);
        check_val("t6_checksum", checksum, 32'd10440);

        // Clear together with a new sof_missing beat
        append_frame(1'b1, -1, -1, W, 20);
        append_frame(1'b1, -1, -1, W, W * H);
        run_beats(0, 0);
        cycle(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
        check_val("t7_err", {28'd0, err}, 32'h1);

        // Randomized frames with faults, gaps, stalls and clears
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(2) == 0) append_stray($urandom_range(1, 4));
            if ($urandom_range(3) == 0) append_frame(1'b0, -1, -1, W, $urandom_range(1, W * H - 1));
            append_frame(1'b0,
                         ($urandom_range(2) == 0) ? $urandom_range(H - 1) : -1,
                         ($urandom_range(2) == 0) ? $urandom_range(H - 1) : -1,
                         $urandom_range(1, W - 1), W * H);
            run_beats(2, 25);
            if ($urandom_range(1) == 0) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
